// File: rtl/dht11_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dht11_pkg
// Brief    : Scheduler state encoding, register map and field bit positions.
// Revision : 1.0
// ============================================================================
package dht11_pkg;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_GAP_WAIT   = 3'd1,
      ST_START      = 3'd2,
      ST_CAPTURE    = 3'd3,
      ST_CHECK      = 3'd4,
      ST_RETRY_WAIT = 3'd5
   } state_t;

   localparam logic [2:0] c_ADDR_CTRL   = 3'd0;
   localparam logic [2:0] c_ADDR_PERIOD = 3'd1;
   localparam logic [2:0] c_ADDR_STATUS = 3'd2;
   localparam logic [2:0] c_ADDR_DATA   = 3'd3;
   localparam logic [2:0] c_ADDR_ERRCNT = 3'd4;

   localparam int c_CTRL_ENABLE  = 0;
   localparam int c_CTRL_ONESHOT = 1;
   localparam int c_CTRL_IRQ_EN  = 2;

   localparam int c_STAT_VALID    = 0;
   localparam int c_STAT_BUSY     = 1;
   localparam int c_STAT_ERR_CSUM = 2;
   localparam int c_STAT_ERR_TMO  = 3;
   localparam int c_STAT_IRQ_PEND = 4;

   // Frame is {hum_int, hum_dec, temp_int, temp_dec, checksum}
   function automatic logic csum_ok(input logic [39:0] frame);
      logic [7:0] sum;
      sum = frame[39:32] + frame[31:24] + frame[23:16] + frame[15:8];
      return (sum == frame[7:0]);
   endfunction

endpackage
`default_nettype wire

// File: rtl/dht11_interval_timer.sv
`default_nettype none
// ============================================================================
// Module   : dht11_interval_timer
// Brief    : Saturating cycles-since-start counters with look-ahead reached flags.
// Revision : 1.0
// ============================================================================
module dht11_interval_timer #(
   parameter int unsigned MIN_GAP_CYC = 1000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        clear,
   input  logic [31:0] period_eff,
   output logic        gap_reached,
   output logic        period_reached
);

   localparam logic [31:0] c_GAP_LIM = (MIN_GAP_CYC > 0) ? 32'(MIN_GAP_CYC - 1) : 32'd0;

   logic [31:0] r_gap_cnt;
   logic [31:0] r_period_cnt;
   logic [32:0] w_period_ahead;

   // clear is issued in the cap_start cycle, so the following cycle is 1 cycle after it
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_gap_cnt    <= '0;
         r_period_cnt <= '0;
      end else if (clear) begin
         r_gap_cnt    <= 32'd1;
         r_period_cnt <= 32'd1;
      end else begin
         if (r_gap_cnt != '1)
            r_gap_cnt <= r_gap_cnt + 32'd1;
         if (r_period_cnt != '1)
            r_period_cnt <= r_period_cnt + 32'd1;
      end
   end

   // Flags lead the START cycle: GAP_WAIT needs one cycle, IDLE->GAP_WAIT->START needs two
   assign w_period_ahead = {1'b0, r_period_cnt} + 33'd2;
   assign gap_reached    = (r_gap_cnt >= c_GAP_LIM);
   assign period_reached = (w_period_ahead >= {1'b0, period_eff});

endmodule
`default_nettype wire

// File: rtl/dht11_sample_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : dht11_sample_scheduler
// Brief    : Avalon-MM DHT11 sampling scheduler with gap enforcement and retries.
// Revision : 1.0
// ============================================================================
module dht11_sample_scheduler #(
   parameter int unsigned CLK_HZ      = 50000000,
   parameter int unsigned MIN_GAP_CYC = CLK_HZ,
   parameter int unsigned MAX_RETRY   = 3
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [2:0]  avs_address,
   input  logic        avs_write,
   input  logic        avs_read,
   input  logic [31:0] avs_writedata,
   output logic [31:0] avs_readdata,
   output logic        irq,
   output logic        cap_start,
   input  logic        cap_busy,
   input  logic        cap_done,
   input  logic        cap_timeout,
   input  logic [39:0] cap_frame
);
   import dht11_pkg::*;

   localparam logic [31:0]        c_MIN_GAP   = 32'(MIN_GAP_CYC);
   localparam int                 c_RETRY_W   = (MAX_RETRY < 2) ? 1 : $clog2(MAX_RETRY + 1);
   localparam logic [c_RETRY_W-1:0] c_RETRY_LIM = c_RETRY_W'(MAX_RETRY);

   state_t                r_state, w_state_nxt;
   logic                  r_enable, r_irq_en;
   logic [31:0]           r_period;
   logic                  r_valid, r_err_csum, r_err_tmo, r_irq_pend;
   logic [31:0]           r_data;
   logic [15:0]           r_cnt_csum, r_cnt_tmo;
   logic [39:0]           r_frame;
   logic                  r_last_tmo;
   logic [c_RETRY_W-1:0]  r_retry;

   logic        w_wr_ctrl, w_wr_period, w_wr_status, w_wr_errcnt, w_oneshot;
   logic [31:0] w_period_eff, w_ctrl_rd, w_status_rd;
   logic        w_gap_reached, w_period_reached;
   logic        w_tmr_clear, w_pass, w_csum_bad, w_cap_tmo, w_retry_again, w_give_up;
   logic        w_unused;

   assign w_wr_ctrl   = avs_write && (avs_address == c_ADDR_CTRL);
   assign w_wr_period = avs_write && (avs_address == c_ADDR_PERIOD);
   assign w_wr_status = avs_write && (avs_address == c_ADDR_STATUS);
   assign w_wr_errcnt = avs_write && (avs_address == c_ADDR_ERRCNT);
   assign w_oneshot   = w_wr_ctrl && avs_writedata[c_CTRL_ONESHOT];

   assign w_period_eff = (r_period < c_MIN_GAP) ? c_MIN_GAP : r_period;
   assign w_unused     = cap_busy;

   dht11_interval_timer #(
      .MIN_GAP_CYC (MIN_GAP_CYC)
   ) u_timer (
      .clk            (clk),
      .reset_n        (reset_n),
      .clear          (w_tmr_clear),
      .period_eff     (w_period_eff),
      .gap_reached    (w_gap_reached),
      .period_reached (w_period_reached)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt   = r_state;
      w_tmr_clear   = 1'b0;
      w_pass        = 1'b0;
      w_csum_bad    = 1'b0;
      w_cap_tmo     = 1'b0;
      w_retry_again = 1'b0;
      w_give_up     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (w_oneshot || (r_enable && w_period_reached))
               w_state_nxt = ST_GAP_WAIT;
         end
         ST_GAP_WAIT: begin
            if (w_gap_reached)
               w_state_nxt = ST_START;
         end
         ST_START: begin
            w_tmr_clear = 1'b1;
            w_state_nxt = ST_CAPTURE;
         end
         ST_CAPTURE: begin
            if (cap_timeout) begin
               w_cap_tmo   = 1'b1;
               w_state_nxt = ST_RETRY_WAIT;
            end else if (cap_done) begin
               w_state_nxt = ST_CHECK;
            end
         end
         ST_CHECK: begin
            if (csum_ok(r_frame)) begin
               w_pass      = 1'b1;
               w_state_nxt = ST_IDLE;
            end else begin
               w_csum_bad  = 1'b1;
               w_state_nxt = ST_RETRY_WAIT;
            end
         end
         ST_RETRY_WAIT: begin
            if (r_retry < c_RETRY_LIM) begin
               w_retry_again = 1'b1;
               w_state_nxt   = ST_GAP_WAIT;
            end else begin
               w_give_up   = 1'b1;
               w_state_nxt = ST_IDLE;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   assign cap_start = (r_state == ST_START);
   assign irq       = r_irq_pend && r_irq_en;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_enable   <= 1'b0;
         r_irq_en   <= 1'b0;
         r_period   <= c_MIN_GAP;
         r_valid    <= 1'b0;
         r_err_csum <= 1'b0;
         r_err_tmo  <= 1'b0;
         r_irq_pend <= 1'b0;
         r_data     <= '0;
         r_cnt_csum <= '0;
         r_cnt_tmo  <= '0;
         r_frame    <= '0;
         r_last_tmo <= 1'b0;
         r_retry    <= '0;
      end else begin
         if (w_wr_ctrl) begin
            r_enable <= avs_writedata[c_CTRL_ENABLE];
            r_irq_en <= avs_writedata[c_CTRL_IRQ_EN];
         end
         if (w_wr_period)
            r_period <= avs_writedata;
         if ((r_state == ST_CAPTURE) && cap_done)
            r_frame <= cap_frame;

         if (w_cap_tmo)
            r_last_tmo <= 1'b1;
         else if (w_csum_bad)
            r_last_tmo <= 1'b0;

         if (w_pass) begin
            r_data     <= r_frame[39:8];
            r_valid    <= 1'b1;
            r_err_csum <= 1'b0;
            r_err_tmo  <= 1'b0;
         end else if (w_give_up) begin
            if (r_last_tmo)
               r_err_tmo <= 1'b1;
            else
               r_err_csum <= 1'b1;
         end

         if (w_pass || w_give_up)
            r_retry <= '0;
         else if (w_retry_again)
            r_retry <= r_retry + 1'b1;

         // Internal set takes priority over a same-cycle write-1-to-clear
         if (w_pass || w_give_up)
            r_irq_pend <= 1'b1;
         else if (w_wr_status && avs_writedata[c_STAT_IRQ_PEND])
            r_irq_pend <= 1'b0;

         if (w_wr_errcnt) begin
            r_cnt_csum <= '0;
            r_cnt_tmo  <= '0;
         end else if (r_state == ST_RETRY_WAIT) begin
            if (r_last_tmo) begin
               if (r_cnt_tmo != 16'hFFFF)
                  r_cnt_tmo <= r_cnt_tmo + 16'd1;
            end else begin
               if (r_cnt_csum != 16'hFFFF)
                  r_cnt_csum <= r_cnt_csum + 16'd1;
            end
         end
      end
   end

   always_comb begin
      w_ctrl_rd                  = '0;
      w_ctrl_rd[c_CTRL_ENABLE]   = r_enable;
      w_ctrl_rd[c_CTRL_IRQ_EN]   = r_irq_en;
      w_status_rd                  = '0;
      w_status_rd[c_STAT_VALID]    = r_valid;
      w_status_rd[c_STAT_BUSY]     = (r_state != ST_IDLE);
      w_status_rd[c_STAT_ERR_CSUM] = r_err_csum;
      w_status_rd[c_STAT_ERR_TMO]  = r_err_tmo;
      w_status_rd[c_STAT_IRQ_PEND] = r_irq_pend;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         avs_readdata <= '0;
      end else if (avs_read) begin
         case (avs_address)
            c_ADDR_CTRL:   avs_readdata <= w_ctrl_rd;
            c_ADDR_PERIOD: avs_readdata <= r_period;
            c_ADDR_STATUS: avs_readdata <= w_status_rd;
            c_ADDR_DATA:   avs_readdata <= r_data;
            c_ADDR_ERRCNT: avs_readdata <= {r_cnt_csum, r_cnt_tmo};
            default:       avs_readdata <= '0;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_dht11_sample_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_dht11_sample_scheduler
// Brief    : Scoreboard bench for the DHT11 sample scheduler.
// Revision : 1.0
// ============================================================================
module tb_dht11_sample_scheduler;

   localparam int unsigned CLK_HZ      = 1000;
   localparam int unsigned MIN_GAP_CYC = 1000;
   localparam int unsigned MAX_RETRY   = 3;

   logic        clk           = 1'b0;
   logic        reset_n       = 1'b0;
   logic [2:0]  avs_address   = '0;
   logic        avs_write     = 1'b0;
   logic        avs_read      = 1'b0;
   logic [31:0] avs_writedata = '0;
   logic [31:0] avs_readdata;
   logic        irq;
   logic        cap_start;
   logic        cap_busy      = 1'b0;
   logic        cap_done      = 1'b0;
   logic        cap_timeout   = 1'b0;
   logic [39:0] cap_frame     = '0;

   dht11_sample_scheduler #(
      .CLK_HZ      (CLK_HZ),
      .MIN_GAP_CYC (MIN_GAP_CYC),
      .MAX_RETRY   (MAX_RETRY)
   ) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .avs_address   (avs_address),
      .avs_write     (avs_write),
      .avs_read      (avs_read),
      .avs_writedata (avs_writedata),
      .avs_readdata  (avs_readdata),
      .irq           (irq),
      .cap_start     (cap_start),
      .cap_busy      (cap_busy),
      .cap_done      (cap_done),
      .cap_timeout   (cap_timeout),
      .cap_frame     (cap_frame)
   );

   always #5 clk = ~clk;

   int          n_chk = 0;
   int          n_err = 0;
   int          cyc;
   int          start_seen = 0;
   int          last_start = 0;
   int          exp_start_q[$];
   logic [31:0] rd_exp_q[$];
   string       rd_tag_q[$];
   logic        rd_vld;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Cycle index counts rising edges since reset release
   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cyc    <= 0;
         rd_vld <= 1'b0;
      end else begin
         cyc    <= cyc + 1;
         rd_vld <= avs_read;
      end
   end

   always @(negedge clk) begin : mon
      int e;
      if (reset_n && cap_start) begin
         if (exp_start_q.size() == 0) begin
            chk("unexpected_start", 32'(cyc), 32'hFFFF_FFFF);
         end else begin
            e = exp_start_q.pop_front();
            chk("start_cycle", 32'(cyc), 32'(e));
         end
         start_seen++;
         last_start = cyc;
      end
      if (rd_vld && (rd_exp_q.size() != 0))
         chk(rd_tag_q.pop_front(), avs_readdata, rd_exp_q.pop_front());
   end

   function automatic logic [39:0] mk_frame(input logic [31:0] d, input logic corrupt);
      logic [7:0] s;
      s = d[31:24] + d[23:16] + d[15:8] + d[7:0];
      if (corrupt)
         s = s - 8'd1;
      return {d, s};
   endfunction

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input logic [2:0] a, input logic [31:0] d);
      @(negedge clk);
      avs_address   = a;
      avs_writedata = d;
      avs_write     = 1'b1;
      @(negedge clk);
      avs_write     = 1'b0;
   endtask

   task automatic rd(input logic [2:0] a, input logic [31:0] e, input string tag);
      rd_exp_q.push_back(e);
      rd_tag_q.push_back(tag);
      @(negedge clk);
      avs_address = a;
      avs_read    = 1'b1;
      @(negedge clk);
      avs_read    = 1'b0;
   endtask

   task automatic expect_start(input int e, input string tag);
      int n0;
      bit seen;
      n0   = start_seen;
      seen = 1'b0;
      exp_start_q.push_back(e);
      for (int i = 0; i < 4000 && !seen; i++) begin
         @(negedge clk);
         #1;
         if (start_seen != n0)
            seen = 1'b1;
      end
      if (!seen) begin
         chk({tag, "_timeout"}, 32'd0, 32'd1);
         exp_start_q.delete();
      end
   endtask

   task automatic respond(input logic [39:0] f, input logic d, input logic t);
      cap_busy = 1'b1;
      tick(3);
      cap_frame   = f;
      cap_done    = d;
      cap_timeout = t;
      @(negedge clk);
      cap_done    = 1'b0;
      cap_timeout = 1'b0;
      cap_busy    = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got 0x00000000 expected 0x00000001");
      $fatal(1, "watchdog expired");
   end

   initial begin
      tick(3);
      chk("rst_cap_start", 32'(cap_start), 32'd0);
      chk("rst_irq", 32'(irq), 32'd0);
      chk("rst_readdata", avs_readdata, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;

      // Scenario 1: early oneshot, first start held off until the power-up gap
      while (cyc < 10) @(negedge clk);
      wr(3'd0, 32'h6);
      rd(3'd0, 32'h4, "s1_ctrl");
      rd(3'd1, 32'd1000, "s1_period_rst");
      rd(3'd2, 32'h2, "s1_status_busy");
      rd(3'd3, 32'h0, "s1_data_rst");
      rd(3'd4, 32'h0, "s1_errcnt_rst");
      rd(3'd7, 32'h0, "s1_unmapped");
      expect_start(1000, "s1_start");
      respond(mk_frame(32'h2300_1900, 1'b0), 1'b1, 1'b0);
      tick(3);
      rd(3'd3, 32'h2300_1900, "s1_data");
      rd(3'd2, 32'h11, "s1_status");
      chk("s1_irq", 32'(irq), 32'd1);
      wr(3'd2, 32'h10);
      rd(3'd2, 32'h01, "s1_status_clr");
      chk("s1_irq_clr", 32'(irq), 32'd0);

      // Scenario 2: three checksum failures then a good frame
      wr(3'd0, 32'h6);
      for (int k = 0; k < 3; k++) begin
         expect_start(last_start + 1000, "s2_retry");
         respond(mk_frame(32'h2400_180A, 1'b1), 1'b1, 1'b0);
      end
      expect_start(last_start + 1000, "s2_final");
      respond(mk_frame(32'h2400_180A, 1'b0), 1'b1, 1'b0);
      tick(3);
      rd(3'd4, 32'h0003_0000, "s2_errcnt");
      rd(3'd2, 32'h11, "s2_status");
      rd(3'd3, 32'h2400_180A, "s2_data");
      wr(3'd4, 32'h0);
      wr(3'd2, 32'h10);

      // Scenario 3: four timeouts exhaust the retries
      wr(3'd0, 32'h6);
      for (int k = 0; k < 4; k++) begin
         expect_start(last_start + 1000, "s3_start");
         respond(40'h0, 1'b0, 1'b1);
      end
      tick(3);
      rd(3'd2, 32'h19, "s3_status");
      rd(3'd4, 32'h0000_0004, "s3_errcnt");
      rd(3'd3, 32'h2400_180A, "s3_data_kept");
      chk("s3_irq", 32'(irq), 32'd1);
      wr(3'd4, 32'h0);
      wr(3'd2, 32'h10);

      // Scenario 5: done and timeout together count as a timeout
      wr(3'd0, 32'h2);
      expect_start(last_start + 1000, "s5_start");
      respond(mk_frame(32'h1122_3344, 1'b0), 1'b1, 1'b1);
      tick(3);
      rd(3'd3, 32'h2400_180A, "s5_data_kept");
      rd(3'd4, 32'h0000_0001, "s5_errcnt");
      rd(3'd2, 32'h0B, "s5_status");
      expect_start(last_start + 1000, "s5_retry");
      respond(mk_frame(32'h1122_3344, 1'b0), 1'b1, 1'b0);
      tick(3);
      rd(3'd3, 32'h1122_3344, "s5_data");
      rd(3'd2, 32'h11, "s5_status_ok");
      wr(3'd4, 32'h0);
      wr(3'd2, 32'h10);

      // Scenario 4: periodic mode, short period clamped then long period honoured
      wr(3'd1, 32'd300);
      rd(3'd1, 32'd300, "s4_period");
      wr(3'd0, 32'h1);
      for (int k = 0; k < 3; k++) begin
         expect_start(last_start + 1000, "s4_clamped");
         respond(mk_frame(32'h3000_1A00 + 32'(k), 1'b0), 1'b1, 1'b0);
      end
      wr(3'd1, 32'd2500);
      for (int k = 0; k < 2; k++) begin
         expect_start(last_start + 2500, "s4_long");
         if (k == 1)
            wr(3'd0, 32'h0);
         respond(mk_frame(32'h3100_1B00 + 32'(k), 1'b0), 1'b1, 1'b0);
      end
      tick(3);
      rd(3'd3, 32'h3100_1B01, "s4_data");
      rd(3'd4, 32'h0, "s4_errcnt");
      rd(3'd2, 32'h11, "s4_status");

      // Scenario 6: reset mid-capture, late cap_done ignored, gap restarts from reset
      wr(3'd0, 32'h2);
      expect_start(last_start + 1000, "s6_start");
      tick(1);
      reset_n = 1'b0;
      @(negedge clk);
      chk("s6_rst_cap_start", 32'(cap_start), 32'd0);
      chk("s6_rst_irq", 32'(irq), 32'd0);
      chk("s6_rst_readdata", avs_readdata, 32'd0);
      reset_n = 1'b1;
      respond(mk_frame(32'h5566_7788, 1'b0), 1'b1, 1'b0);
      tick(3);
      rd(3'd2, 32'h0, "s6_status");
      rd(3'd3, 32'h0, "s6_data");
      rd(3'd1, 32'd1000, "s6_period");
      rd(3'd0, 32'h0, "s6_ctrl");
      wr(3'd0, 32'h2);
      expect_start(1000, "s6_first_start");
      tick(2);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
`default_nettype wire
